id_ex_alu_feed: RTL and testbench

- ID/EX pipeline stage that sits directly upstream of ALUCentral.
- Captures decoded operands and control from ID and decodes ALUOp/funct into the 4-bit ALUControl.
- Applies EX/MEM and MEM/WB forwarding, drives ALUCentral's dado_1/dado_2/ALUControl, and detects load-use hazards for the hazard unit.

---
 rtl/id_ex_alu_feed_pkg.sv | 34 +++
 rtl/id_ex_alu_feed_alu_control_decode.sv | 39 +++
 rtl/id_ex_alu_feed.sv | 148 ++++++++++++++
 tb/tb_id_ex_alu_feed.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_alu_feed_pkg.sv
// Shared encodings for the ID/EX stage and the ALU control decoder:
// ALUControl codes, main-control ALUOp classes and R-type funct values.
package id_ex_alu_feed_pkg;

    // ALU function codes understood by ALUCentral
    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_ctl_e;

    // ALU class produced by main control
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_OR    = 2'b11
    } alu_op_e;

    // Supported R-type funct fields
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    // Control code driven while the stage holds a bubble or is in reset
    localparam logic [3:0] ALU_CTL_IDLE = 4'b0010;

endpackage

// File: rtl/id_ex_alu_feed_alu_control_decode.sv
// Combinational ALUOp + funct -> ALUControl decoder. Shared with the
// single-cycle datapath; unknown R-type functs fall back to add and raise
// the illegal flag.
module alu_control_decode
    import id_ex_alu_feed_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [5:0] funct,
    output logic [3:0] ALUControl,
    output logic       illegal_funct
);

    // Map ALU class (and funct for R-type) to the ALU function code
    always_comb begin
        ALUControl    = ALU_ADD;
        illegal_funct = 1'b0;
        case (alu_op_e'(ALUOp))
            ALUOP_ADD: ALUControl = ALU_ADD;
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_OR:  ALUControl = ALU_OR;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: ALUControl = ALU_ADD;
                    FUNCT_SUB: ALUControl = ALU_SUB;
                    FUNCT_AND: ALUControl = ALU_AND;
                    FUNCT_OR:  ALUControl = ALU_OR;
                    FUNCT_SLT: ALUControl = ALU_SLT;
                    FUNCT_NOR: ALUControl = ALU_NOR;
                    default: begin
                        ALUControl    = ALU_ADD;
                        illegal_funct = 1'b1;
                    end
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/id_ex_alu_feed.sv
// ID/EX pipeline register feeding ALUCentral. Captures decoded operands and
// control, decodes ALUControl, applies EX/MEM and MEM/WB forwarding to the
// ALU operands and reports load-use hazards to the hazard unit.
module id_ex_alu_feed
    import id_ex_alu_feed_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [5:0]        id_funct,
    input  logic [1:0]        id_ALUOp,
    input  logic              id_ALUSrc,
    input  logic              id_RegDst,
    input  logic              id_RegWrite,
    input  logic              id_MemRead,
    input  logic              id_MemWrite,
    input  logic              stall,
    input  logic              flush,
    input  logic              exmem_RegWrite,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_RegWrite,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [DATA_W-1:0] dado_1,
    output logic [DATA_W-1:0] dado_2,
    output logic [3:0]        ALUControl,
    output logic              ex_valid,
    output logic              ex_RegWrite,
    output logic              ex_MemRead,
    output logic              ex_MemWrite,
    output logic [REG_AW-1:0] ex_dest,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              load_use_hazard,
    output logic              illegal_funct
);

    logic [3:0]        dec_ctl;
    logic              dec_illegal;
    logic              alusrc_q;
    logic [REG_AW-1:0] rs_q;
    logic [REG_AW-1:0] rt_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic              take_bubble;

    alu_control_decode u_alu_control_decode (
        .ALUOp         (id_ALUOp),
        .funct         (id_funct),
        .ALUControl    (dec_ctl),
        .illegal_funct (dec_illegal)
    );

    // A producing stage matches a source only if it writes a non-zero register
    function automatic logic fwd_hit(input logic we, input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] src);
        return we && (rd != '0) && (rd == src);
    endfunction

    // flush wins over stall; an invalid ID slot is captured as a bubble too
    assign take_bubble = flush || (!stall && !id_valid);

    // Stage register: reset/bubble clear, stall holds, otherwise capture ID
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_valid      <= 1'b0;
            ex_RegWrite   <= 1'b0;
            ex_MemRead    <= 1'b0;
            ex_MemWrite   <= 1'b0;
            alusrc_q      <= 1'b0;
            illegal_funct <= 1'b0;
            ALUControl    <= ALU_CTL_IDLE;
            ex_dest       <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            imm_q         <= '0;
        end else if (take_bubble) begin
            ex_valid      <= 1'b0;
            ex_RegWrite   <= 1'b0;
            ex_MemRead    <= 1'b0;
            ex_MemWrite   <= 1'b0;
            alusrc_q      <= 1'b0;
            illegal_funct <= 1'b0;
            ALUControl    <= ALU_CTL_IDLE;
            ex_dest       <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            imm_q         <= '0;
        end else if (!stall) begin
            ex_valid      <= 1'b1;
            ex_RegWrite   <= id_RegWrite;
            ex_MemRead    <= id_MemRead;
            ex_MemWrite   <= id_MemWrite;
            alusrc_q      <= id_ALUSrc;
            illegal_funct <= dec_illegal;
            ALUControl    <= dec_ctl;
            ex_dest       <= id_RegDst ? id_rd : id_rt;
            rs_q          <= id_rs;
            rt_q          <= id_rt;
            rs_data_q     <= id_rs_data;
            rt_data_q     <= id_rt_data;
            imm_q         <= id_imm;
        end
    end

    // Forwarding muxes: EX/MEM has priority over MEM/WB, else register value
    always_comb begin
        fwd_a = rs_data_q;
        if (fwd_hit(exmem_RegWrite, exmem_rd, rs_q))
            fwd_a = exmem_result;
        else if (fwd_hit(memwb_RegWrite, memwb_rd, rs_q))
            fwd_a = memwb_result;

        fwd_b = rt_data_q;
        if (fwd_hit(exmem_RegWrite, exmem_rd, rt_q))
            fwd_b = exmem_result;
        else if (fwd_hit(memwb_RegWrite, memwb_rd, rt_q))
            fwd_b = memwb_result;
    end

    assign dado_1        = fwd_a;
    assign ex_store_data = fwd_b;
    assign dado_2        = alusrc_q ? imm_q : fwd_b;

    // Load in EX whose destination feeds the instruction now in ID; rt only
    // counts when ID actually reads it (register operand, not immediate)
    always_comb begin
        load_use_hazard = ex_valid && ex_MemRead && (ex_dest != '0) && id_valid &&
                          ((ex_dest == id_rs) || ((ex_dest == id_rt) && !id_ALUSrc));
    end

endmodule

// File: tb/tb_id_ex_alu_feed.sv
// Scoreboard bench for id_ex_alu_feed: each driven cycle pushes the expected
// stage contents; after the edge they are popped and compared, with operand
// expectations built from the current forwarding inputs.
module tb_id_ex_alu_feed;

    logic        clock = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [5:0]  id_funct;
    logic [1:0]  id_ALUOp;
    logic        id_ALUSrc, id_RegDst, id_RegWrite, id_MemRead, id_MemWrite;
    logic        stall, flush;
    logic        exmem_RegWrite, memwb_RegWrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] dado_1, dado_2, ex_store_data;
    logic [3:0]  ALUControl;
    logic        ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite;
    logic [4:0]  ex_dest;
    logic        load_use_hazard, illegal_funct;

    id_ex_alu_feed #(.DATA_W(32), .REG_AW(5)) dut (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
        .id_ALUOp(id_ALUOp), .id_ALUSrc(id_ALUSrc), .id_RegDst(id_RegDst),
        .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
        .stall(stall), .flush(flush),
        .exmem_RegWrite(exmem_RegWrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_RegWrite(memwb_RegWrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .dado_1(dado_1), .dado_2(dado_2), .ALUControl(ALUControl),
        .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
        .ex_MemWrite(ex_MemWrite), .ex_dest(ex_dest), .ex_store_data(ex_store_data),
        .load_use_hazard(load_use_hazard), .illegal_funct(illegal_funct)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        valid, rw, mr, mw, alusrc, illegal;
        logic [4:0]  rs, rt, dest;
        logic [31:0] rs_data, rt_data, imm;
        logic [3:0]  aluc;
    } exp_t;

    exp_t q[$];
    exp_t held;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic exp_t bubble();
        exp_t e;
        e.valid = 0; e.rw = 0; e.mr = 0; e.mw = 0; e.alusrc = 0; e.illegal = 0;
        e.rs = 0; e.rt = 0; e.dest = 0; e.rs_data = 0; e.rt_data = 0; e.imm = 0;
        e.aluc = 4'b0010;
        return e;
    endfunction

    // Reference ALUControl table
    function automatic logic [4:0] ref_ctl(input logic [1:0] op, input logic [5:0] f);
        // {illegal, code}
        case (op)
            2'b00: return {1'b0, 4'b0010};
            2'b01: return {1'b0, 4'b0110};
            2'b11: return {1'b0, 4'b0001};
            default: case (f)
                6'b100000: return {1'b0, 4'b0010};
                6'b100010: return {1'b0, 4'b0110};
                6'b100100: return {1'b0, 4'b0000};
                6'b100101: return {1'b0, 4'b0001};
                6'b101010: return {1'b0, 4'b0111};
                6'b100111: return {1'b0, 4'b1100};
                default:   return {1'b1, 4'b0010};
            endcase
        endcase
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] cap);
        if (exmem_RegWrite && exmem_rd != 0 && exmem_rd == src) return exmem_result;
        if (memwb_RegWrite && memwb_rd != 0 && memwb_rd == src) return memwb_result;
        return cap;
    endfunction

    task automatic check_outputs(input string tag, input exp_t e);
        logic [31:0] b;
        logic        lu;
        b  = fwd(e.rt, e.rt_data);
        lu = e.valid && e.mr && e.dest != 0 && id_valid &&
             (e.dest == id_rs || (e.dest == id_rt && !id_ALUSrc));
        check({tag, ".valid"},   {31'b0, ex_valid},        {31'b0, e.valid});
        check({tag, ".rw"},      {31'b0, ex_RegWrite},     {31'b0, e.rw});
        check({tag, ".mr"},      {31'b0, ex_MemRead},      {31'b0, e.mr});
        check({tag, ".mw"},      {31'b0, ex_MemWrite},     {31'b0, e.mw});
        check({tag, ".dest"},    {27'b0, ex_dest},         {27'b0, e.dest});
        check({tag, ".aluc"},    {28'b0, ALUControl},      {28'b0, e.aluc});
        check({tag, ".illegal"}, {31'b0, illegal_funct},   {31'b0, e.illegal});
        check({tag, ".dado_1"},  dado_1,                   fwd(e.rs, e.rs_data));
        check({tag, ".dado_2"},  dado_2,                   e.alusrc ? e.imm : b);
        check({tag, ".store"},   ex_store_data,            b);
        check({tag, ".luh"},     {31'b0, load_use_hazard}, {31'b0, lu});
    endtask

    // Push what the stage should hold after the next edge
    task automatic push_next();
        exp_t       e;
        logic [4:0] d;
        if (flush || (!stall && !id_valid)) e = bubble();
        else if (stall) e = held;
        else begin
            d = ref_ctl(id_ALUOp, id_funct);
            e.valid = 1; e.rw = id_RegWrite; e.mr = id_MemRead; e.mw = id_MemWrite;
            e.alusrc = id_ALUSrc; e.illegal = d[4]; e.aluc = d[3:0];
            e.rs = id_rs; e.rt = id_rt; e.dest = id_RegDst ? id_rd : id_rt;
            e.rs_data = id_rs_data; e.rt_data = id_rt_data; e.imm = id_imm;
        end
        held = e;
        q.push_back(e);
    endtask

    task automatic step(input string tag);
        exp_t e;
        push_next();
        @(posedge clock);
        #1;
        if (q.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = q.pop_front();
            check_outputs(tag, e);
        end
    endtask

    task automatic set_id(input logic [1:0] op, input logic [5:0] f, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b, input logic src);
        id_valid = 1; id_ALUOp = op; id_funct = f; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = a; id_rt_data = b; id_ALUSrc = src; id_RegDst = 1;
        id_RegWrite = 1; id_MemRead = 0; id_MemWrite = 0; id_imm = 32'h0000_0040;
    endtask

    task automatic clear_fwd();
        exmem_RegWrite = 0; exmem_rd = 0; exmem_result = 0;
        memwb_RegWrite = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    logic [1:0] ops   [8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11};
    logic [5:0] functs[8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                              6'b100111, 6'b000000, 6'b111111, 6'b101010};

    initial begin
        reset = 1; stall = 0; flush = 0;
        set_id(2'b00, 6'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        id_valid = 0;
        clear_fwd();
        #12;
        held = bubble();
        check_outputs("reset", held);
        reset = 0;
        #4;

        // R-type slt and an unsupported funct
        set_id(2'b10, 6'b101010, 5'd1, 5'd2, 5'd3, 32'd3, 32'd5, 1'b0);
        step("slt");
        check("slt.aluc_lit", {28'b0, ALUControl}, 32'h7);
        set_id(2'b10, 6'b000111, 5'd1, 5'd2, 5'd3, 32'd3, 32'd5, 1'b0);
        step("illegal");
        check("illegal.flag", {31'b0, illegal_funct}, 32'd1);

        // Remaining decode classes
        for (int i = 0; i < 8; i++) begin
            set_id(ops[i], functs[i], 5'(i + 10), 5'(i + 11), 5'(i + 12),
                   32'(i * 3), 32'(i * 7), 1'b0);
            step($sformatf("dec%0d", i));
        end

        // Invalid ID slot captures as a bubble
        id_valid = 0;
        step("idv0");

        // Forwarding priority on operand A
        set_id(2'b10, 6'b100000, 5'd8, 5'd4, 5'd6, 32'hAA, 32'hBB, 1'b0);
        step("fwd_cap");
        exmem_RegWrite = 1; exmem_rd = 8; exmem_result = 32'h11;
        memwb_RegWrite = 1; memwb_rd = 8; memwb_result = 32'h22;
        #1; check_outputs("fwd_exmem", held);
        check("fwd_exmem.lit", dado_1, 32'h11);
        exmem_RegWrite = 0;
        #1; check_outputs("fwd_memwb", held);
        check("fwd_memwb.lit", dado_1, 32'h22);
        exmem_RegWrite = 1; exmem_rd = 0; memwb_rd = 0;
        set_id(2'b10, 6'b100000, 5'd0, 5'd4, 5'd6, 32'h55, 32'hBB, 1'b0);
        step("fwd_r0");
        check("fwd_r0.lit", dado_1, 32'h55);
        clear_fwd();

        // Immediate operand with forwarded store data
        set_id(2'b00, 6'b0, 5'd2, 5'd7, 5'd3, 32'h1, 32'h99, 1'b1);
        id_imm = 32'hFFFF_FFFC;
        step("imm");
        exmem_RegWrite = 1; exmem_rd = 7; exmem_result = 32'h7;
        #1; check_outputs("imm_fwd", held);
        check("imm.dado_2", dado_2, 32'hFFFF_FFFC);
        check("imm.store", ex_store_data, 32'h7);
        clear_fwd();

        // Load-use detection, flush response, immediate exemption
        set_id(2'b00, 6'b0, 5'd1, 5'd9, 5'd0, 32'h100, 32'h0, 1'b1);
        id_RegDst = 0; id_MemRead = 1;
        step("lw");
        set_id(2'b10, 6'b100000, 5'd9, 5'd3, 5'd4, 32'h0, 32'h0, 1'b0);
        #1; check("lu_rs", {31'b0, load_use_hazard}, 32'd1);
        flush = 1;
        step("lu_flush");
        flush = 0;
        set_id(2'b00, 6'b0, 5'd1, 5'd9, 5'd0, 32'h100, 32'h0, 1'b1);
        id_RegDst = 0; id_MemRead = 1;
        step("lw2");
        set_id(2'b00, 6'b0, 5'd2, 5'd9, 5'd4, 32'h0, 32'h0, 1'b1);
        #1; check_outputs("lu_imm", held);
        check("lu_imm.lit", {31'b0, load_use_hazard}, 32'd0);
        id_ALUSrc = 0;
        #1; check("lu_rt", {31'b0, load_use_hazard}, 32'd1);

        // Stall holds for three cycles, stall+flush captures a bubble
        set_id(2'b10, 6'b100101, 5'd5, 5'd6, 5'd7, 32'h1234, 32'h5678, 1'b0);
        step("pre_stall");
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_id(2'b01, 6'b0, 5'(i + 20), 5'(i + 21), 5'd1, 32'(i), 32'(i), 1'b1);
            step($sformatf("stall%0d", i));
            check($sformatf("stall%0d.dado_1", i), dado_1, 32'h1234);
        end
        flush = 1;
        step("stall_flush");
        stall = 0; flush = 0;

        // Mid-pipeline asynchronous reset
        set_id(2'b10, 6'b100010, 5'd3, 5'd4, 5'd5, 32'hDEAD, 32'hBEEF, 1'b0);
        step("pre_reset");
        #2; reset = 1; #1;
        held = bubble();
        check_outputs("mid_reset", held);
        #3; reset = 0;
        q.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
